decode_pipe_buffer: RTL and testbench
=====================================

# decode_pipe_buffer

- Elastic ID/EX pipeline register between the decode stage and the execute stage of the pipelined core.
- Replaces the free-running decode latch with a two-entry skid buffer: valid/ready handshake on both sides, registered `in_ready`, and a squash (`flush`) input for branch/JAL redirects.
- Payload widths are parametrised.
- Instruction order is always preserved and no accepted instruction is duplicated or lost except by `flush`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of `rs1_data`, `rs2_data`, `extend_imm`.
- `ADDRESS_BITS`, 20: width of `inst_PC`, `branch_target`, `JAL_target`.
- `CORE`, 0: core index; carried for instantiation symmetry, no functional effect.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `flush`  in  1  squash all buffered instructions.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  buffer can accept; registered.
- `rs1_data`  in  DATA_WIDTH  source operand 1.
- `rs2_data`  in  DATA_WIDTH  source operand 2.
- `extend_imm`  in  DATA_WIDTH  sign-extended immediate.
- `decode_ctrl`  in  22  packed {funct7[21:15], funct3[14:12], rd[11:7], opcode[6:0]}.
- `inst_PC`  in  ADDRESS_BITS  instruction PC.
- `branch_target`  in  ADDRESS_BITS  precomputed branch target.
- `JAL_target`  in  ADDRESS_BITS  precomputed JAL target.
- `out_valid`  out  1  execute-side instruction valid.
- `out_ready`  in  1  execute consumes this cycle.
- `reg_rs1_data`, `reg_rs2_data`, `reg_extend_imm`  out  DATA_WIDTH each  head-entry fields.
- `reg_decode_ctrl`  out  22  head-entry control.
- `reg_inst_PC`, `reg_branch_target`, `reg_JAL_target`  out  ADDRESS_BITS each  head-entry addresses.

## Operation
Storage:
- Two entries: MAIN (drives `reg_*`, valid bit = `out_valid`) and SKID.
- `in_ready` = !skid_valid, held in a flop.
- accept = `in_valid` & `in_ready`; drain = `out_valid` & `out_ready`.

States and transitions:
- EMPTY (neither valid): accept → load MAIN → ONE.
- ONE (MAIN only):
  - accept & drain → MAIN ← input, stay ONE.
  - accept & !drain → SKID ← input → FULL; `in_ready` drops next cycle.
  - !accept & drain → EMPTY.
- FULL (both valid): no accept possible.
  - drain → MAIN ← SKID, SKID invalid → ONE.
  - !drain → hold.

Flush and reset:
- `flush`=1 has priority over everything but reset. Both valid bits clear → EMPTY. An input offered that cycle is dropped. Payload flops are unchanged (don't-care).
- Reset (`reset`=0 at posedge) clears both valid bits and all payload to 0. Outputs after reset: `out_valid`=0, `in_ready`=1, all `reg_*`=0. Reset overrides `flush` and handshakes.

Rules:
- Payload is never modified in flight; widths pass through unchanged, no arithmetic.
- `reg_*` are stable while `out_valid`=1 & `out_ready`=0.

## Timing
- Latency: accepted at edge N into EMPTY/ONE-with-drain → `out_valid`=1 with that payload after edge N (1 cycle).
- Throughput: 1 instruction/cycle while `out_ready`=1.
- The `in_ready` deassertion is seen by decode one cycle after SKID fills. The SKID entry absorbs the single instruction accepted in that cycle; no combinational ready path from `out_ready` to `in_ready`.
- After flush at edge N: `out_valid`=0 and `in_ready`=1 after edge N. A new instruction may be accepted at edge N+1.
- Simultaneous flush+accept: input discarded. Simultaneous flush+drain: the drained entry counts as consumed by execute; buffer empties.

## Configuration
- `DECODE_PIPE_BUFFER_STATS_EN` defined: adds outputs `stall_cycles` [15:0] and `flush_count` [15:0].
  - `stall_cycles` increments each cycle `out_valid` & !`out_ready`.
  - `flush_count` increments each cycle `flush`=1 while any entry is valid.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counters absent; datapath behaviour identical.

## Test plan
- Reset: drive `reset`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `reg_inst_PC`=0, `reg_rs1_data`=0.
- Streaming: `out_ready`=1, instructions with PC 0x00004, 0x00008, 0x0000C on consecutive cycles → same PCs on `reg_inst_PC` one cycle later each, `out_valid` continuous, `in_ready` never drops.
- Backpressure: `out_ready`=0, offer A (rs1=0x11111111) then B (rs1=0x22222222) → `in_ready`=0 after B; C held by decode. Raise `out_ready` → A, B, C exit in order with no duplicate.
- Flush in FULL: fill A and B, assert `flush` while offering C → `out_valid`=0 next cycle, C never appears; `in_ready`=1 next cycle.
- Reset mid-operation: FULL state with `flush`=1, then `reset`=0 → all outputs at reset values next cycle; the next accepted instruction appears alone.
- Stats (macro defined): 70000 cycles `out_valid`=1, `out_ready`=0 → `stall_cycles`=16'hFFFF, holds. Three flushes with data buffered → `flush_count`=3.

Source files
------------

// File: rtl/decode_pipe_buffer_if.sv
// Handshake and payload bundle between the decode stage and the ID/EX buffer.
// master: decode/execute environment view; slave: the buffer itself.
interface decode_pipe_buffer_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   rs1_data;
    logic [DATA_WIDTH-1:0]   rs2_data;
    logic [DATA_WIDTH-1:0]   extend_imm;
    logic [21:0]             decode_ctrl;
    logic [ADDRESS_BITS-1:0] inst_PC;
    logic [ADDRESS_BITS-1:0] branch_target;
    logic [ADDRESS_BITS-1:0] JAL_target;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   reg_rs1_data;
    logic [DATA_WIDTH-1:0]   reg_rs2_data;
    logic [DATA_WIDTH-1:0]   reg_extend_imm;
    logic [21:0]             reg_decode_ctrl;
    logic [ADDRESS_BITS-1:0] reg_inst_PC;
    logic [ADDRESS_BITS-1:0] reg_branch_target;
    logic [ADDRESS_BITS-1:0] reg_JAL_target;

    modport master (
        output in_valid, rs1_data, rs2_data, extend_imm, decode_ctrl,
               inst_PC, branch_target, JAL_target, out_ready,
        input  in_ready, out_valid, reg_rs1_data, reg_rs2_data, reg_extend_imm,
               reg_decode_ctrl, reg_inst_PC, reg_branch_target, reg_JAL_target
    );

    modport slave (
        input  in_valid, rs1_data, rs2_data, extend_imm, decode_ctrl,
               inst_PC, branch_target, JAL_target, out_ready,
        output in_ready, out_valid, reg_rs1_data, reg_rs2_data, reg_extend_imm,
               reg_decode_ctrl, reg_inst_PC, reg_branch_target, reg_JAL_target
    );
endinterface

// File: rtl/decode_pipe_buffer.sv
// Two-entry elastic ID/EX register (MAIN + SKID) with registered in_ready and flush.
// Optional DECODE_PIPE_BUFFER_STATS_EN adds saturating stall/flush counters.
//
// state | meaning
// EMPTY | no entry valid
// ONE   | MAIN valid, SKID free
// FULL  | MAIN and SKID valid, in_ready low
module decode_pipe_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int CORE         = 0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    decode_pipe_buffer_if.slave   bus
`ifdef DECODE_PIPE_BUFFER_STATS_EN
    ,
    output logic [15:0]           stall_cycles_o,
    output logic [15:0]           flush_count_o
`endif
);
    localparam int PW = 3*DATA_WIDTH + 22 + 3*ADDRESS_BITS;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [PW-1:0]   main_q, main_d;
    logic [PW-1:0]   skid_q, skid_d;
    logic [PW-1:0]   in_pl;
    logic            out_valid_w;
    logic            accept;
    logic            drain;
    logic            core_unused;

    assign core_unused = (CORE != 0);

    assign in_pl = {bus.rs1_data, bus.rs2_data, bus.extend_imm, bus.decode_ctrl,
                    bus.inst_PC, bus.branch_target, bus.JAL_target};
    assign {bus.reg_rs1_data, bus.reg_rs2_data, bus.reg_extend_imm, bus.reg_decode_ctrl,
            bus.reg_inst_PC, bus.reg_branch_target, bus.reg_JAL_target} = main_q;

    assign out_valid_w  = (state_q != EMPTY);
    assign bus.out_valid = out_valid_w;
    assign bus.in_ready  = in_ready_q;
    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_w & bus.out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = in_pl;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d = in_pl;
                    end else if (accept) begin
                        skid_d  = in_pl;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Ready is a flop: it reflects whether SKID will be free after this edge.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef DECODE_PIPE_BUFFER_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] flushes_q, flushes_d;

    always_comb begin
        stall_d   = stall_q;
        flushes_d = flushes_q;
        if (out_valid_w && !bus.out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if (flush_i && out_valid_w && (flushes_q != 16'hFFFF)) begin
            flushes_d = flushes_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            stall_q   <= '0;
            flushes_q <= '0;
        end else begin
            stall_q   <= stall_d;
            flushes_q <= flushes_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flushes_q;
`endif
endmodule

// File: tb/tb_decode_pipe_buffer.sv
// Directed plus randomized bench for decode_pipe_buffer against a queue-based model.
module tb_decode_pipe_buffer;
    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [21:0] ctrl;
        logic [19:0] pc;
        logic [19:0] bt;
        logic [19:0] jt;
    } pl_t;

    logic clk;
    logic rst_b;
    logic flush;
    int   n_asserts = 0;
    int   n_fail    = 0;

    pl_t         q[$];
    pl_t         exp_main;
    pl_t         cur_in;
    logic [31:0] drained[$];
    int          exp_stall;
    int          exp_flush;

    decode_pipe_buffer_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) bus ();

`ifdef DECODE_PIPE_BUFFER_STATS_EN
    logic [15:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    decode_pipe_buffer #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .CORE(0)) dut (
        .clock_i (clk),
        .reset_i (rst_b),
        .flush_i (flush),
        .bus     (bus)
`ifdef DECODE_PIPE_BUFFER_STATS_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic pl_t rnd_pl();
        pl_t p;
        p.rs1  = $urandom;
        p.rs2  = $urandom;
        p.imm  = $urandom;
        p.ctrl = 22'($urandom);
        p.pc   = 20'($urandom);
        p.bt   = 20'($urandom);
        p.jt   = 20'($urandom);
        return p;
    endfunction

    function automatic pl_t mk_pl(input logic [31:0] rs1, input logic [19:0] pc);
        pl_t p;
        p      = rnd_pl();
        p.rs1  = rs1;
        p.pc   = pc;
        return p;
    endfunction

    task automatic drive(input bit v, input pl_t p, input bit ordy, input bit fl, input bit rb);
        cur_in            = p;
        bus.in_valid      = v;
        bus.rs1_data      = p.rs1;
        bus.rs2_data      = p.rs2;
        bus.extend_imm    = p.imm;
        bus.decode_ctrl   = p.ctrl;
        bus.inst_PC       = p.pc;
        bus.branch_target = p.bt;
        bus.JAL_target    = p.jt;
        bus.out_ready     = ordy;
        flush             = fl;
        rst_b             = rb;
    endtask

    // One clock: advance the model from the inputs presented, then compare 1 ns later.
    task automatic tick();
        int  cnt;
        @(posedge clk);
        cnt = q.size();
        if (!rst_b) begin
            q.delete();
            exp_main  = '0;
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (cnt > 0 && !bus.out_ready && exp_stall < 65535) exp_stall++;
            if (cnt > 0 && flush && exp_flush < 65535) exp_flush++;
            if (flush) begin
                q.delete();
            end else begin
                if (cnt > 0 && bus.out_ready) drained.push_back(q.pop_front().rs1);
                if (bus.in_valid && cnt < 2) q.push_back(cur_in);
            end
            if (q.size() > 0) exp_main = q[0];
        end
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        chk("reg_rs1_data", 64'(bus.reg_rs1_data), 64'(exp_main.rs1));
        chk("reg_rs2_data", 64'(bus.reg_rs2_data), 64'(exp_main.rs2));
        chk("reg_extend_imm", 64'(bus.reg_extend_imm), 64'(exp_main.imm));
        chk("reg_decode_ctrl", 64'(bus.reg_decode_ctrl), 64'(exp_main.ctrl));
        chk("reg_inst_PC", 64'(bus.reg_inst_PC), 64'(exp_main.pc));
        chk("reg_branch_target", 64'(bus.reg_branch_target), 64'(exp_main.bt));
        chk("reg_JAL_target", 64'(bus.reg_JAL_target), 64'(exp_main.jt));
`ifdef DECODE_PIPE_BUFFER_STATS_EN
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        chk("flush_count", 64'(flush_count), 64'(exp_flush));
`endif
    endtask

    initial begin
        pl_t a, b, c, d;
        bit  acc;
        exp_main  = '0;
        exp_stall = 0;
        exp_flush = 0;

        // reset held two cycles while decode offers an instruction
        drive(1'b1, rnd_pl(), 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_inst_PC", 64'(bus.reg_inst_PC), 64'd0);
        chk("rst_rs1", 64'(bus.reg_rs1_data), 64'd0);

        // streaming at full rate
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk_pl($urandom, 20'(4*i)), 1'b1, 1'b0, 1'b1);
            tick();
            chk("stream_pc", 64'(bus.reg_inst_PC), 64'(4*i));
            chk("stream_ready", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, rnd_pl(), 1'b1, 1'b0, 1'b1);
        tick();

        // backpressure: A and B fill the buffer, C is held until accepted
        drained.delete();
        a = mk_pl(32'h11111111, 20'h00100);
        b = mk_pl(32'h22222222, 20'h00104);
        c = mk_pl(32'h33333333, 20'h00108);
        drive(1'b1, a, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, b, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
        drive(1'b1, c, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        bus.out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = (q.size() < 2);
            tick();
        end
        chk("bp_c_accepted", 64'(acc), 64'd1);
        drive(1'b0, rnd_pl(), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drain_count", 64'(drained.size()), 64'd3);
        if (drained.size() == 3) begin
            chk("bp_order_a", 64'(drained[0]), 64'h11111111);
            chk("bp_order_b", 64'(drained[1]), 64'h22222222);
            chk("bp_order_c", 64'(drained[2]), 64'h33333333);
        end

        // flush in FULL while C is offered
        drive(1'b1, a, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, b, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, c, 1'b0, 1'b1, 1'b1);
        tick();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        drive(1'b0, rnd_pl(), 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_c_absent", 64'(bus.out_valid), 64'd0);

        // reset while FULL with flush asserted
        drive(1'b1, a, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, b, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, c, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_pc", 64'(bus.reg_inst_PC), 64'd0);
        d = mk_pl(32'h44444444, 20'h00200);
        drive(1'b1, d, 1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_mid_d", 64'(bus.reg_rs1_data), 64'h44444444);
        drive(1'b0, rnd_pl(), 1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_mid_alone", 64'(bus.out_valid), 64'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, rnd_pl(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 99) < 3, !($urandom_range(0, 199) == 0));
            tick();
        end

`ifdef DECODE_PIPE_BUFFER_STATS_EN
        drive(1'b0, rnd_pl(), 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, rnd_pl(), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, rnd_pl(), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 70000; i++) tick();
        chk("stall_saturated", 64'(stall_cycles), 64'hFFFF);
        tick();
        chk("stall_holds", 64'(stall_cycles), 64'hFFFF);

        drive(1'b0, rnd_pl(), 1'b0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, rnd_pl(), 1'b0, 1'b0, 1'b1);
            tick();
            drive(1'b0, rnd_pl(), 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, rnd_pl(), 1'b0, 1'b1, 1'b1);
        tick();
        chk("flush_count_3", 64'(flush_count), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
